// File: rtl/wb_load_unit_if.sv
// Bundle of the MEM/WB handshake, data-memory response and register-file write port
// seen by the writeback load unit.
interface wb_load_unit_if #(
  parameter int DATA_WIDTH = 64
);
  logic                  wb_valid;
  logic                  wb_ready;
  logic                  wb_reg_write;
  logic                  wb_is_load;
  logic [4:0]            wb_rd_addr;
  logic [2:0]            wb_funct3;
  logic [2:0]            wb_addr_low;
  logic [DATA_WIDTH-1:0] wb_alu_result;
  logic                  mem_rsp_valid;
  logic [DATA_WIDTH-1:0] mem_rsp_data;
  logic                  rf_we;
  logic [4:0]            rf_rd_addr;
  logic [DATA_WIDTH-1:0] rf_rd_data;
  logic                  load_pending;
  logic [4:0]            pending_rd;
  logic                  err_timeout;

  // Upstream pipeline / memory side.
  modport master (
    output wb_valid, wb_reg_write, wb_is_load, wb_rd_addr, wb_funct3, wb_addr_low,
           wb_alu_result, mem_rsp_valid, mem_rsp_data,
    input  wb_ready, rf_we, rf_rd_addr, rf_rd_data, load_pending, pending_rd, err_timeout
  );

  // The writeback load unit itself.
  modport slave (
    input  wb_valid, wb_reg_write, wb_is_load, wb_rd_addr, wb_funct3, wb_addr_low,
           wb_alu_result, mem_rsp_valid, mem_rsp_data,
    output wb_ready, rf_we, rf_rd_addr, rf_rd_data, load_pending, pending_rd, err_timeout
  );
endinterface

// File: rtl/wb_load_unit.sv
// Writeback-stage register-file write driver. ALU results are written one cycle after
// accept; loads wait for a data-memory response (bounded by LOAD_TIMEOUT), then the
// addressed byte lane is extracted and sign/zero extended. The tag of an outstanding load
// is exported so decode can stall on RAW hazards.
module wb_load_unit #(
  parameter int DATA_WIDTH   = 64,
  parameter int LOAD_TIMEOUT = 16
) (
  input logic           clk,
  input logic           rst_n,
  wb_load_unit_if.slave bus
);

  localparam logic [0:0] IDLE      = 1'b0;
  localparam logic [0:0] WAIT_LOAD = 1'b1;

  localparam int              CW      = (LOAD_TIMEOUT > 2) ? $clog2(LOAD_TIMEOUT) : 1;
  localparam logic [CW-1:0]   CNT_MAX = CW'(LOAD_TIMEOUT - 1);

  logic [0:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [4:0]            rd_q, rd_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [2:0]            off_q, off_d;
  logic                  rf_we_q, rf_we_d;
  logic [4:0]            rf_rd_addr_q, rf_rd_addr_d;
  logic [DATA_WIDTH-1:0] rf_rd_data_q, rf_rd_data_d;
  logic [4:0]            pending_rd_q, pending_rd_d;
  logic                  err_timeout_q, err_timeout_d;
  logic [63:0]           load_result;

  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] lane_w;

  // Byte-lane extraction of the response; misaligned offsets fall back to natural alignment.
  always_comb begin
    lane_b      = bus.mem_rsp_data[{off_q, 3'b000} +: 8];
    lane_h      = bus.mem_rsp_data[{off_q[2:1], 4'b0000} +: 16];
    lane_w      = bus.mem_rsp_data[{off_q[2], 5'b00000} +: 32];
    load_result = bus.mem_rsp_data;
    case (funct3_q)
      3'b000:  load_result = {{56{lane_b[7]}}, lane_b};
      3'b001:  load_result = {{48{lane_h[15]}}, lane_h};
      3'b010:  load_result = {{32{lane_w[31]}}, lane_w};
      3'b100:  load_result = {56'd0, lane_b};
      3'b101:  load_result = {48'd0, lane_h};
      3'b110:  load_result = {32'd0, lane_w};
      default: load_result = bus.mem_rsp_data; // LD and reserved 111
    endcase
  end

  // Next-state logic: accept in IDLE, wait for the response or the timeout in WAIT_LOAD.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    rd_d          = rd_q;
    funct3_d      = funct3_q;
    off_d         = off_q;
    rf_we_d       = 1'b0;
    rf_rd_addr_d  = rf_rd_addr_q;
    rf_rd_data_d  = rf_rd_data_q;
    pending_rd_d  = pending_rd_q;
    err_timeout_d = err_timeout_q;
    case (state_q)
      IDLE: begin
        if (bus.wb_valid) begin
          if (!bus.wb_is_load) begin
            rf_we_d      = bus.wb_reg_write && (bus.wb_rd_addr != 5'd0);
            rf_rd_addr_d = bus.wb_rd_addr;
            rf_rd_data_d = bus.wb_alu_result;
          end else begin
            rd_d         = bus.wb_rd_addr;
            funct3_d     = bus.wb_funct3;
            off_d        = bus.wb_addr_low;
            cnt_d        = '0;
            pending_rd_d = bus.wb_rd_addr;
            state_d      = WAIT_LOAD;
          end
        end
      end
      default: begin
        cnt_d = cnt_q + 1'b1;
        if (bus.mem_rsp_valid) begin
          // A response coinciding with the timeout still wins.
          rf_we_d      = (rd_q != 5'd0);
          rf_rd_addr_d = rd_q;
          rf_rd_data_d = load_result;
          pending_rd_d = 5'd0;
          state_d      = IDLE;
        end else if (cnt_q == CNT_MAX) begin
          pending_rd_d  = 5'd0;
          err_timeout_d = 1'b1;
          state_d       = IDLE;
        end
      end
    endcase
  end

  // State and output registers; reset abandons any outstanding load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      rd_q          <= 5'd0;
      funct3_q      <= 3'd0;
      off_q         <= 3'd0;
      rf_we_q       <= 1'b0;
      rf_rd_addr_q  <= 5'd0;
      rf_rd_data_q  <= '0;
      pending_rd_q  <= 5'd0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rd_q          <= rd_d;
      funct3_q      <= funct3_d;
      off_q         <= off_d;
      rf_we_q       <= rf_we_d;
      rf_rd_addr_q  <= rf_rd_addr_d;
      rf_rd_data_q  <= rf_rd_data_d;
      pending_rd_q  <= pending_rd_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign bus.wb_ready     = (state_q == IDLE);
  assign bus.load_pending = (state_q == WAIT_LOAD);
  assign bus.rf_we        = rf_we_q;
  assign bus.rf_rd_addr   = rf_rd_addr_q;
  assign bus.rf_rd_data   = rf_rd_data_q;
  assign bus.pending_rd   = pending_rd_q;
  assign bus.err_timeout  = err_timeout_q;

endmodule

// File: tb/tb_wb_load_unit.sv
// Scoreboard bench for wb_load_unit: stimulus pushes expected register writes, a monitor
// pops and compares on every rf_we pulse.
module tb_wb_load_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_load_unit_if #(.DATA_WIDTH(64)) bus ();

  wb_load_unit #(.DATA_WIDTH(64), .LOAD_TIMEOUT(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [4:0]  addr;
    logic [63:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  tests = 0;
  int  fails = 0;

  // Reference load result from the ISA rules: size, natural alignment, extension.
  function automatic logic [63:0] ref_load(input logic [2:0] f3, input logic [2:0] off,
                                           input logic [63:0] data);
    int nbytes, aligned;
    logic [63:0] v, mask;
    case (f3[1:0])
      2'd0: nbytes = 1;
      2'd1: nbytes = 2;
      2'd2: nbytes = 4;
      default: nbytes = 8;
    endcase
    if (f3 == 3'b111) nbytes = 8;
    aligned = int'(off) - (int'(off) % nbytes);
    v = data >> (8 * aligned);
    if (nbytes < 8) begin
      mask = (64'd1 << (8 * nbytes)) - 64'd1;
      v = v & mask;
      if (!f3[2] && v[8 * nbytes - 1]) v = v | ~mask;
    end
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.wb_valid = 1'b0;
    bus.wb_reg_write = 1'b0;
    bus.wb_is_load = 1'b0;
    bus.wb_rd_addr = 5'd0;
    bus.wb_funct3 = 3'd0;
    bus.wb_addr_low = 3'd0;
    bus.wb_alu_result = 64'd0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data = 64'd0;
  endtask

  task automatic do_alu(input logic [4:0] rd, input logic [63:0] val, input logic rw);
    bus.wb_valid = 1'b1;
    bus.wb_is_load = 1'b0;
    bus.wb_reg_write = rw;
    bus.wb_rd_addr = rd;
    bus.wb_alu_result = val;
    if (rw && rd != 5'd0) exp_q.push_back('{addr: rd, data: val});
    step();
    bus.wb_valid = 1'b0;
    check("alu_ready_after", 64'(bus.wb_ready), 64'd1);
    $display("[TB] alu rd=%0d val=0x%016h rw=%0d", rd, val, rw);
  endtask

  // Response arrives dly cycles after the accept edge; dly<=16 is written.
  task automatic do_load(input logic [4:0] rd, input logic [2:0] f3, input logic [2:0] off,
                         input logic [63:0] data, input int dly);
    bus.wb_valid = 1'b1;
    bus.wb_is_load = 1'b1;
    bus.wb_reg_write = 1'b1;
    bus.wb_rd_addr = rd;
    bus.wb_funct3 = f3;
    bus.wb_addr_low = off;
    step();
    bus.wb_valid = 1'b0;
    bus.wb_is_load = 1'b0;
    check("load_pending_set", 64'(bus.load_pending), 64'd1);
    check("pending_rd_tag", 64'(bus.pending_rd), 64'(rd));
    check("ready_low_wait", 64'(bus.wb_ready), 64'd0);
    repeat (dly - 1) step();
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data = data;
    if (dly <= 16 && rd != 5'd0) exp_q.push_back('{addr: rd, data: ref_load(f3, off, data)});
    step();
    bus.mem_rsp_valid = 1'b0;
    check("ready_after_rsp", 64'(bus.wb_ready), 64'd1);
    check("pending_clear", 64'(bus.load_pending), 64'd0);
    check("pending_rd_zero", 64'(bus.pending_rd), 64'd0);
    $display("[TB] load rd=%0d f3=%0d off=%0d data=0x%016h dly=%0d", rd, f3, off, data, dly);
  endtask

  // Monitor: every register-file write must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n && bus.rf_we) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write: got addr=%0d data=0x%016h expected no write",
                 bus.rf_rd_addr, bus.rf_rd_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (bus.rf_rd_addr !== e.addr || bus.rf_rd_data !== e.data) begin
          fails++;
          $display("FAIL rf_write: got addr=%0d data=0x%016h expected addr=%0d data=0x%016h",
                   bus.rf_rd_addr, bus.rf_rd_data, e.addr, e.data);
        end else begin
          $display("[TB] write ok addr=%0d data=0x%016h", e.addr, e.data);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    #12;
    check("rst_rf_we", 64'(bus.rf_we), 64'd0);
    check("rst_rf_addr", 64'(bus.rf_rd_addr), 64'd0);
    check("rst_rf_data", bus.rf_rd_data, 64'd0);
    check("rst_pending_rd", 64'(bus.pending_rd), 64'd0);
    check("rst_err", 64'(bus.err_timeout), 64'd0);
    check("rst_ready", 64'(bus.wb_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Directed cases
    do_alu(5'd5, 64'h1234, 1'b1);
    do_alu(5'd0, 64'hDEAD, 1'b1);
    do_alu(5'd7, 64'hBEEF, 1'b0);
    do_load(5'd1, 3'b000, 3'd3, 64'h0000_0000_8000_0000, 1);
    do_load(5'd2, 3'b100, 3'd3, 64'h0000_0000_8000_0000, 2);
    do_load(5'd3, 3'b010, 3'd4, 64'h89AB_CDEF_0000_0000, 3);
    do_load(5'd4, 3'b110, 3'd4, 64'h89AB_CDEF_0000_0000, 1);
    do_load(5'd0, 3'b011, 3'd0, 64'h1111_2222_3333_4444, 3);
    do_load(5'd6, 3'b111, 3'd5, 64'hFEDC_BA98_7654_3210, 16);
    check("no_err_yet", 64'(bus.err_timeout), 64'd0);

    // Randomized mix (no timeouts)
    for (int i = 0; i < 300; i++) begin
      logic [4:0]  rd;
      logic [63:0] d;
      rd = 5'($urandom_range(0, 31));
      d  = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 0)
        do_alu(rd, d, 1'($urandom_range(0, 1)));
      else
        do_load(rd, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), d,
                $urandom_range(1, 12));
    end
    check("err_clear_random", 64'(bus.err_timeout), 64'd0);

    // Timeout: no response, IDLE exactly 16 cycles after accept, late response ignored
    bus.wb_valid = 1'b1;
    bus.wb_is_load = 1'b1;
    bus.wb_rd_addr = 5'd9;
    bus.wb_funct3 = 3'b011;
    step();
    bus.wb_valid = 1'b0;
    bus.wb_is_load = 1'b0;
    repeat (15) step();
    check("to_still_wait", 64'(bus.load_pending), 64'd1);
    check("to_no_err_early", 64'(bus.err_timeout), 64'd0);
    step();
    check("to_ready", 64'(bus.wb_ready), 64'd1);
    check("to_err", 64'(bus.err_timeout), 64'd1);
    check("to_pending_rd", 64'(bus.pending_rd), 64'd0);
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data = 64'hAAAA_BBBB_CCCC_DDDD;
    step();
    bus.mem_rsp_valid = 1'b0;
    step();
    check("to_err_sticky", 64'(bus.err_timeout), 64'd1);
    check("to_still_idle", 64'(bus.wb_ready), 64'd1);
    $display("[TB] timeout sequence done");

    // Reset in WAIT_LOAD drops the load
    do_alu(5'd8, 64'h55, 1'b1);
    bus.wb_valid = 1'b1;
    bus.wb_is_load = 1'b1;
    bus.wb_rd_addr = 5'd10;
    step();
    bus.wb_valid = 1'b0;
    bus.wb_is_load = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    check("mrst_pending", 64'(bus.load_pending), 64'd0);
    check("mrst_pending_rd", 64'(bus.pending_rd), 64'd0);
    check("mrst_rf_addr", 64'(bus.rf_rd_addr), 64'd0);
    check("mrst_rf_data", bus.rf_rd_data, 64'd0);
    check("mrst_err", 64'(bus.err_timeout), 64'd0);
    step();
    rst_n = 1'b1;
    #1;
    check("mrst_ready", 64'(bus.wb_ready), 64'd1);
    bus.mem_rsp_valid = 1'b1;
    step();
    bus.mem_rsp_valid = 1'b0;
    do_alu(5'd11, 64'hCAFE_F00D, 1'b1);
    $display("[TB] reset sequence done");

    repeat (3) step();
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
